// File: rtl/hazard_control_unit_if.sv
// Control bundle between the 5-stage pipeline and its hazard control unit.
// The pipeline side (master) supplies ID/EX hazard information; the unit
// side (slave) returns register enables, flushes and MUL/DIV status.
interface hazard_control_unit_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       RS1_ID;
   logic [4:0]       RS2_ID;
   logic             USE_RS2_ID;
   logic [4:0]       RD_EX;
   logic             RF_LE_EX;
   logic             MEM_RD_EX;
   logic             MD_START_EX;
   logic             BR_TAKEN_EX;
   logic             PC_LE;
   logic             IFID_LE;
   logic             IFID_CLR;
   logic             IDEX_LE;
   logic             IDEX_CLR;
   logic             EXMEM_CLR;
   logic             MD_BUSY;
   logic             MD_DONE;
   logic [CNT_W-1:0] STALL_CNT;

   modport master (
      output RS1_ID, RS2_ID, USE_RS2_ID, RD_EX, RF_LE_EX, MEM_RD_EX,
             MD_START_EX, BR_TAKEN_EX,
      input  PC_LE, IFID_LE, IFID_CLR, IDEX_LE, IDEX_CLR, EXMEM_CLR,
             MD_BUSY, MD_DONE, STALL_CNT
   );

   modport slave (
      input  RS1_ID, RS2_ID, USE_RS2_ID, RD_EX, RF_LE_EX, MEM_RD_EX,
             MD_START_EX, BR_TAKEN_EX,
      output PC_LE, IFID_LE, IFID_CLR, IDEX_LE, IDEX_CLR, EXMEM_CLR,
             MD_BUSY, MD_DONE, STALL_CNT
   );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: stalls for load-use hazards, flushes on
// taken branches resolved in EX, and freezes the front end while a
// multi-cycle MUL/DIV occupies EX. Also counts front-end stall cycles.
module hazard_control_unit #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 16
) (
   input logic                 clk,
   input logic                 rst,
   hazard_control_unit_if.slave bus
);

   typedef enum logic {RUN, MD_WAIT} state_t;

   // The first hold cycle is the start cycle itself, the release cycle is
   // the last one, so the down-counter covers the remaining MD_LATENCY-2.
   localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 2);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       cnt;
   logic [7:0]       cnt_nxt;
   logic [CNT_W-1:0] stall_cnt;

   logic md_hold;
   logic load_use;
   logic pc_le;
   logic ifid_le;
   logic ifid_clr;
   logic idex_le;
   logic idex_clr;
   logic exmem_clr;
   logic md_done;

   // State and MUL/DIV down-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic and control outputs; MD hold beats branch beats load-use.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pc_le     = 1'b1;
      ifid_le   = 1'b1;
      ifid_clr  = 1'b0;
      idex_le   = 1'b1;
      idex_clr  = 1'b0;
      exmem_clr = 1'b0;
      md_done   = 1'b0;
      md_hold   = 1'b0;
      load_use  = bus.MEM_RD_EX && bus.RF_LE_EX && (bus.RD_EX != 5'd0) &&
                  ((bus.RD_EX == bus.RS1_ID) ||
                   (bus.USE_RS2_ID && (bus.RD_EX == bus.RS2_ID)));
      if (!rst) begin
         case (state)
            RUN: begin
               if (bus.MD_START_EX) begin
                  md_hold   = 1'b1;
                  cnt_nxt   = MD_LOAD;
                  state_nxt = MD_WAIT;
               end
            end
            MD_WAIT: begin
               if (cnt != 8'd0) begin
                  md_hold = 1'b1;
                  cnt_nxt = cnt - 8'd1;
               end else begin
                  md_done   = 1'b1;
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase

         if (md_hold) begin
            pc_le     = 1'b0;
            ifid_le   = 1'b0;
            idex_le   = 1'b0;
            exmem_clr = 1'b1;
         end else if (bus.BR_TAKEN_EX) begin
            // ID holds a wrong-path instruction, so its load-use stall is moot.
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
         end else if (load_use) begin
            pc_le    = 1'b0;
            ifid_le  = 1'b0;
            idex_clr = 1'b1;
         end
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (!pc_le && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign bus.PC_LE     = pc_le;
   assign bus.IFID_LE   = ifid_le;
   assign bus.IFID_CLR  = ifid_clr;
   assign bus.IDEX_LE   = idex_le;
   assign bus.IDEX_CLR  = idex_clr;
   assign bus.EXMEM_CLR = exmem_clr;
   assign bus.MD_DONE   = md_done;
   assign bus.MD_BUSY   = (state == MD_WAIT);
   assign bus.STALL_CNT = stall_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed and random stimulus, expected
// control vectors from a cycle-age reference model, checked via scoreboard.
module tb_hazard_control_unit;

   localparam int MD_LATENCY = 4;
   localparam int CNT_W      = 16;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   typedef struct packed {
      logic             pc_le;
      logic             ifid_le;
      logic             ifid_clr;
      logic             idex_le;
      logic             idex_clr;
      logic             exmem_clr;
      logic             md_busy;
      logic             md_done;
      logic [CNT_W-1:0] stall_cnt;
   } vec_t;

   logic clk;
   logic rst;

   hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

   hazard_control_unit #(
      .MD_LATENCY(MD_LATENCY),
      .CNT_W     (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vec_t  sb[$];
   int    checks = 0;
   int    passes = 0;
   int    cycle  = 0;

   // Reference model: age of the MUL/DIV op in EX (-1 = none), stall total.
   int    md_age = -1;
   int    stalls = 0;

   // Monitor: compare the DUT outputs against the queued expectation.
   always @(negedge clk) begin
      vec_t e;
      vec_t a;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = {bus.PC_LE, bus.IFID_LE, bus.IFID_CLR, bus.IDEX_LE, bus.IDEX_CLR,
              bus.EXMEM_CLR, bus.MD_BUSY, bus.MD_DONE, bus.STALL_CNT};
         checks++;
         if (a === e) passes++;
         else $display("FAIL ctrl cycle %0d: actual %h required %h (pc,ifid_le,ifid_clr,idex_le,idex_clr,exmem_clr,busy,done,cnt)",
                       cycle, a, e);
      end
   end

   task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic rfle,
                       input logic mrd, input logic mds, input logic br);
      vec_t e;
      int   age_now;
      logic hold;
      logic lu;
      rst             = r;
      bus.RS1_ID      = rs1;
      bus.RS2_ID      = rs2;
      bus.USE_RS2_ID  = u2;
      bus.RD_EX       = rd;
      bus.RF_LE_EX    = rfle;
      bus.MEM_RD_EX   = mrd;
      bus.MD_START_EX = mds;
      bus.BR_TAKEN_EX = br;

      e           = '0;
      e.pc_le     = 1'b1;
      e.ifid_le   = 1'b1;
      e.idex_le   = 1'b1;
      e.md_busy   = (md_age >= 1);
      e.stall_cnt = CNT_W'(stalls);
      if (r) begin
         md_age = -1;
         stalls = 0;
      end else begin
         age_now = (md_age < 0) ? (mds ? 0 : -1) : md_age;
         hold    = (age_now >= 0) && (age_now <= MD_LATENCY - 2);
         lu      = mrd && rfle && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
         if (hold) begin
            e.pc_le     = 1'b0;
            e.ifid_le   = 1'b0;
            e.idex_le   = 1'b0;
            e.exmem_clr = 1'b1;
         end else begin
            e.md_done = (age_now == MD_LATENCY - 1);
            if (br) begin
               e.ifid_clr = 1'b1;
               e.idex_clr = 1'b1;
            end else if (lu) begin
               e.pc_le    = 1'b0;
               e.ifid_le  = 1'b0;
               e.idex_clr = 1'b1;
            end
         end
         md_age = hold ? age_now + 1 : -1;
         if (!e.pc_le && stalls < CNT_MAX) stalls++;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst             = 1'b1;
      bus.RS1_ID      = '0;
      bus.RS2_ID      = '0;
      bus.USE_RS2_ID  = 1'b0;
      bus.RD_EX       = '0;
      bus.RF_LE_EX    = 1'b0;
      bus.MEM_RD_EX   = 1'b0;
      bus.MD_START_EX = 1'b1;
      bus.BR_TAKEN_EX = 1'b0;
      @(posedge clk);
      #1;

      // Reset held with MD start requested.
      step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle();

      // Load-use positive, then the negative cases.
      step(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      idle();
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      idle();

      // MD op with start held through the release cycle.
      for (int i = 0; i < MD_LATENCY; i++)
         step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle();

      // Branch in the same cycle as a load-use match.
      step(1'b0, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
      idle();

      // Branch while MD holds, then a branch in the release cycle.
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      idle();

      // Reset in the second cycle of an MD op.
      step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < MD_LATENCY; i++) idle();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 63) == 0),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      end

      // Saturation: long run of load-use stalls after a clean reset.
      step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 70000; i++)
         step(1'b0, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
      idle();
      idle();

      checks++;
      if (sb.size() == 0) passes++;
      else $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage core. It generates stall, hold and flush controls for the PC and the IF/ID, ID/EX and EX/MEM registers.
- It resolves three cases: load-use hazards that forwarding cannot cover, taken branches/jumps resolved in EX, and multi-cycle MUL/DIV operations occupying EX.
- It sits beside the forwarding unit in ID/EX control and keeps a saturating stall-cycle performance counter.

Parameters:
- MD_LATENCY, 4, total cycles a multi-cycle op occupies EX (legal range 2..255).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- RS1_ID  in  5  rs1 of instruction in ID
- RS2_ID  in  5  rs2 of instruction in ID
- USE_RS2_ID  in  1  instruction in ID reads rs2
- RD_EX  in  5  destination register of instruction in EX
- RF_LE_EX  in  1  instruction in EX writes the register file
- MEM_RD_EX  in  1  instruction in EX is a load
- MD_START_EX  in  1  instruction in EX is a multi-cycle MUL/DIV
- BR_TAKEN_EX  in  1  branch/jump in EX resolved taken
- PC_LE  out  1  PC load enable
- IFID_LE  out  1  IF/ID load enable
- IFID_CLR  out  1  IF/ID flush (insert NOP)
- IDEX_LE  out  1  ID/EX load enable
- IDEX_CLR  out  1  ID/EX bubble insert
- EXMEM_CLR  out  1  EX/MEM bubble insert
- MD_BUSY  out  1  registered; state == MD_WAIT
- MD_DONE  out  1  MD result valid this cycle (release cycle)
- STALL_CNT  out  CNT_W  registered saturating count of cycles with PC_LE == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State and counter registers: state ∈ {RUN, MD_WAIT}, plus an 8-bit down-counter cnt.
- Reset values:
  - On rst, next state = RUN, cnt = 0, STALL_CNT = 0.
  - While rst is high, PC_LE = IFID_LE = IDEX_LE = 1 and all CLR outputs = 0, MD_DONE = 0.
  - Reset during MD_WAIT aborts the op with no MD_DONE.
- Control outputs are combinational from the inputs and the current state. Default: all LE = 1, all CLR = 0, MD_DONE = 0.
- MD start (state RUN and MD_START_EX = 1):
  - PC_LE = IFID_LE = IDEX_LE = 0 and EXMEM_CLR = 1.
  - cnt <= MD_LATENCY-2; state <= MD_WAIT.
- MD_WAIT with cnt != 0: same hold pattern as MD start; cnt <= cnt-1. MD_START_EX is ignored (the op is still held in EX).
- MD_WAIT with cnt == 0 (release cycle):
  - No hold and no EXMEM_CLR; MD_DONE = 1; state <= RUN.
  - Branch and load-use logic is evaluated normally this cycle.
- MD timing: the op occupies EX for exactly MD_LATENCY cycles, of which MD_LATENCY-1 are hold cycles.
- Load-use hazard:
  - Condition: MEM_RD_EX & RF_LE_EX & RD_EX != 0 & (RD_EX == RS1_ID | (USE_RS2_ID & RD_EX == RS2_ID)).
  - Response: PC_LE = IFID_LE = 0, IDEX_CLR = 1 for one cycle. The bubble entering EX clears the condition next cycle.
- Taken branch (BR_TAKEN_EX = 1): IFID_CLR = 1, IDEX_CLR = 1, PC_LE = 1 (PC loads target).
- Priority, highest first:
  - MD hold (start or wait).
  - Taken branch: suppresses load-use stall, since the ID instruction is wrong-path.
  - Load-use.
- MD_START_EX and BR_TAKEN_EX must never be high together; if they are, MD hold wins and the branch is ignored.
- STALL_CNT:
  - Increments by 1 at each clk edge where PC_LE == 0 and rst == 0.
  - Saturates at all-ones; never wraps.
  - Branch flush cycles are not counted.

Test Plan:
- Reset: rst = 1 for 2 cycles with MD_START_EX = 1 → PC_LE = 1, IFID_LE = 1, IDEX_LE = 1, all CLR = 0, MD_BUSY = 0, STALL_CNT = 0.
- Load-use, positive case: RD_EX = 5, MEM_RD_EX = 1, RF_LE_EX = 1, RS1_ID = 5 → PC_LE = 0, IFID_LE = 0, IDEX_CLR = 1 for one cycle; STALL_CNT 0 → 1.
- Load-use, negative cases: each of the following → no stall:
  - RD_EX = 0 with RS1_ID = 0.
  - RS2_ID = 5 with USE_RS2_ID = 0.
  - RF_LE_EX = 0.
- MD latency (MD_LATENCY = 4): MD_START_EX = 1 held from cycle T →
  - Hold and EXMEM_CLR = 1 at T, T+1, T+2.
  - MD_BUSY = 1 at T+1..T+3.
  - MD_DONE = 1 only at T+3, with no stall at T+3.
  - STALL_CNT += 3.
- Branch vs load-use: BR_TAKEN_EX = 1 in the same cycle as a load-use match → IFID_CLR = 1, IDEX_CLR = 1, PC_LE = 1, IFID_LE = 1; STALL_CNT unchanged.
- Reset mid-op and saturation:
  - rst pulsed at T+1 of an MD op → at T+2 MD_BUSY = 0, no hold, MD_DONE never asserted.
  - Separately, 70000 consecutive load-use stall cycles → STALL_CNT = 16'hFFFF and stays there.
